contatore_occorrenze: RTL
=========================

# contatore_occorrenze

Counts the single-cycle recognition pulses `z` produced by the upstream sequence recogniser over fixed windows of `WINDOW` clock cycles. At the end of each window it hands the count to a downstream consumer through a four-phase `dav_`/`rfd` handshake. Counting continues during the handshake, so no `z` pulse is lost while a result is being delivered.

## Interface
- `W`, 4: width of count and result.
- `WINDOW`, 8: window length in clock cycles, ≥ 2.
- `clock` input 1: single clock, posedge.
- `reset_` input 1: asynchronous, active-low reset.
- `z` input 1: recognition pulse from the upstream recogniser, sampled on posedge.
- `rfd` input 1: consumer ready-for-data, active high.
- `dav_` output 1: data-available, active low.
- `count` output W: delivered result, valid while `dav_`=0.
- `sat` output 1: result saturated; qualifies `count`.
- `lost` output 1: sticky flag; a window result was discarded.

## Operation
- Accumulator `acc` (W bits) and window counter `wcnt` (0..WINDOW-1) are always running.
  - Each posedge: `wcnt` increments, wrapping to 0 after WINDOW-1.
  - `acc` adds `z`, saturating at 2^W-1. Reaching saturation sets the internal `accsat` flag.
- Window end is the posedge with `wcnt`==WINDOW-1.
  - `acc`+`z` (saturated) and its saturation flag are the window result.
  - `acc` is cleared to 0 and `accsat` to 0 for the next window, so a `z` on the first cycle of the next window is counted.
- Result buffer: `pending` flag, plus `count` and `sat` registers.
  - At window end, if `pending`=0: load `count`/`sat` from the result and set `pending`=1.
  - At window end, if `pending`=1: discard the new result, set `lost`=1, and leave `count`/`sat` unchanged.
- Handshake FSM:
  - `H_IDLE` (`dav_`=1): go to `H_OFFER` when `pending`=1 and `rfd`=1.
  - `H_OFFER` (`dav_`=0, `count` stable): wait for `rfd`=0, then clear `pending` and go to `H_RELEASE`.
  - `H_RELEASE` (`dav_`=1): wait for `rfd`=1, then go to `H_IDLE`.
- Window end coinciding with `rfd` falling in `H_OFFER`: the old result is consumed and the new result is loaded in the same edge. `pending` stays 1 and `lost` is not set.
- `lost` is cleared only by reset.

## Timing
- Reset (asynchronous, immediate):
  - `dav_`=1, `count`=0, `sat`=0, `lost`=0.
  - `pending`=0, `acc`=0, `wcnt`=0, FSM in `H_IDLE`.
- After reset release, the first window covers the first WINDOW posedges.
- Latency: the result is registered at the window-end edge. `dav_` falls at the next posedge if `rfd`=1, otherwise at the first posedge where `rfd`=1.
- `count`/`sat` never change while `dav_`=0.
- `dav_` rises on the posedge that samples `rfd`=0 in `H_OFFER`.
- Minimum handshake: 3 cycles, offer to idle.
- Reset asserted mid-handshake: `dav_` returns to 1 at once and the current result is dropped without setting `lost`.

## Structure
- Shared package holds:
  - FSM state encoding: `H_IDLE`=2'b00, `H_OFFER`=2'b01, `H_RELEASE`=2'b10.
  - Default `W`/`WINDOW` constants.
- One natural sub-module: `accumulatore_finestra`, containing `wcnt`, `acc`, saturation logic and the window-end strobe. The handshake FSM and result buffer stay in the top module.

## Test plan
- Reset, then 8 cycles with `z`=0 and `rfd`=1 → `dav_` falls after the 8th edge, `count`=0, `sat`=0.
- `z`=1 on cycles 1, 4, 7, 8 (including the window-end cycle), `rfd`=1 → `count`=4. A `z` on the first cycle of the next window appears in the following result.
- `z`=1 for 20 consecutive cycles, W=4, WINDOW=8 → `count`=8, `sat`=0 for both windows. With WINDOW=20: `count`=15, `sat`=1.
- Hold `rfd`=1 in `H_OFFER` (consumer never takes data) for 2 windows → `count` frozen at the first value, `lost`=1. After `rfd` drops and rises, the next window's result is offered normally.
- Drop `rfd` on exactly the window-end edge while offering → old result consumed, new result offered after `rfd` returns to 1, `lost`=0.
- Assert `reset_`=0 while `dav_`=0 → `dav_`=1, `count`=0 and `lost`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/contatore_occorrenze_pkg.sv
// Shared constants for the occurrence counter: handshake state encoding and default sizes.
package contatore_occorrenze_pkg;

  localparam int W_DEF      = 4;
  localparam int WINDOW_DEF = 8;

  localparam logic [1:0] H_IDLE    = 2'b00;
  localparam logic [1:0] H_OFFER   = 2'b01;
  localparam logic [1:0] H_RELEASE = 2'b10;

  // Width of the window counter; at least one bit even for the smallest window.
  function automatic int wcnt_width(input int window);
    return (window <= 2) ? 1 : $clog2(window);
  endfunction

endpackage

// File: rtl/contatore_occorrenze_if.sv
// Result delivery bus between the occurrence counter (master) and its consumer (slave).
interface contatore_occorrenze_if #(
  parameter int W = 4
);

  // Four-phase handshake: consumer raises rfd; producer drops dav_ with count/sat
  // stable; consumer drops rfd to take the data; producer raises dav_; consumer
  // raises rfd again before the next offer. lost is a sticky side flag.
  logic         dav_;
  logic [W-1:0] count;
  logic         sat;
  logic         lost;
  logic         rfd;

  modport master (
    output dav_,
    output count,
    output sat,
    output lost,
    input  rfd
  );

  modport slave (
    input  dav_,
    input  count,
    input  sat,
    input  lost,
    output rfd
  );

endinterface

// File: rtl/contatore_occorrenze_accumulatore_finestra.sv
// Free-running window counter and saturating pulse accumulator; flags the last cycle of each window.
module accumulatore_finestra
  import contatore_occorrenze_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         z,
  output logic         fine,
  output logic [W-1:0] res_count,
  output logic         res_sat
);

  localparam int            CW   = wcnt_width(WINDOW);
  localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);
  localparam logic [W-1:0]  MAX  = '1;

  logic [CW-1:0] wcnt;
  logic [W-1:0]  acc;
  logic          accsat;

  assign fine = (wcnt == LAST);

  // Count including this cycle's pulse; doubles as the window result at window end.
  always_comb begin
    res_count = acc;
    if (z && (acc != MAX)) begin
      res_count = acc + W'(1);
    end
    res_sat = accsat | (res_count == MAX);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      wcnt   <= '0;
      acc    <= '0;
      accsat <= 1'b0;
    end else if (fine) begin
      wcnt   <= '0;
      acc    <= '0;
      accsat <= 1'b0;
    end else begin
      wcnt   <= wcnt + CW'(1);
      acc    <= res_count;
      accsat <= res_sat;
    end
  end

endmodule

// File: rtl/contatore_occorrenze.sv
// Counts z pulses per window and delivers each window's result over a four-phase dav_/rfd handshake.
module contatore_occorrenze
  import contatore_occorrenze_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int WINDOW = WINDOW_DEF
) (
  input  logic                    clock,
  input  logic                    reset_,
  input  logic                    z,
  contatore_occorrenze_if.master  hs,
  output logic [1:0]              dbg_stato
);

  logic         fine;
  logic [W-1:0] res_count;
  logic         res_sat;
  logic [1:0]   stato;
  logic         pending;
  logic         consume;

  accumulatore_finestra #(
    .W      (W),
    .WINDOW (WINDOW)
  ) u_acc (
    .clock     (clock),
    .reset_    (reset_),
    .z         (z),
    .fine      (fine),
    .res_count (res_count),
    .res_sat   (res_sat)
  );

  assign consume   = (stato == H_OFFER) && !hs.rfd;
  assign hs.dav_   = (stato != H_OFFER);
  assign dbg_stato = stato;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      stato    <= H_IDLE;
      pending  <= 1'b0;
      hs.count <= '0;
      hs.sat   <= 1'b0;
      hs.lost  <= 1'b0;
    end else begin
      case (stato)
        H_IDLE:    if (pending && hs.rfd) stato <= H_OFFER;
        H_OFFER:   if (!hs.rfd) stato <= H_RELEASE;
        H_RELEASE: if (hs.rfd) stato <= H_IDLE;
        default:   stato <= H_IDLE;
      endcase

      // A result being consumed on this edge frees the buffer for a coinciding window end.
      if (fine) begin
        if (!pending || consume) begin
          hs.count <= res_count;
          hs.sat   <= res_sat;
          pending  <= 1'b1;
        end else begin
          hs.lost  <= 1'b1;
        end
      end else if (consume) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
